// File: rtl/vram_port_arbiter.sv
// Port-A arbiter for the dual-port video RAM: core vs DMA, registered issue stage, 2-cycle read return.
// Define VRAM_ARB_STARVE_GUARD_EN to bound DMA starvation at STARVE_LIMIT consecutive core transfers.
module vram_port_arbiter #(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("vram_port_arbiter: STARVE_LIMIT must be within 1..15");
    end

    logic              dma_force;

    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              rd_issued_q, rd_issued_d;
    owner_e            rd_owner_q, rd_owner_d;
    logic              core_rvalid_q, core_rvalid_d;
    logic              dma_rvalid_q, dma_rvalid_d;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign dma_force = dma_req && (starve_cnt_q == 4'(STARVE_LIMIT));

    // Counts core wins DMA has waited through; any DMA win or idle DMA restarts it.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!dma_req || dma_gnt) begin
            starve_cnt_d = '0;
        end else if (core_gnt && (starve_cnt_q != 4'hF)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign dma_force = 1'b0;
`endif

    assign core_gnt = !reset && core_req && !dma_force;
    assign dma_gnt  = !reset && dma_req && (!core_req || dma_force);

    always_comb begin
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        ram_we_d      = 1'b0;
        rd_issued_d   = 1'b0;
        rd_owner_d    = rd_owner_q;
        if (core_gnt) begin
            ram_addr_d  = core_addr;
            ram_wdata_d = core_wdata;
            ram_we_d    = core_we;
            rd_issued_d = !core_we;
            rd_owner_d  = OWN_CORE;
        end else if (dma_gnt) begin
            ram_addr_d  = dma_addr;
            ram_wdata_d = dma_wdata;
            ram_we_d    = dma_we;
            rd_issued_d = !dma_we;
            rd_owner_d  = OWN_DMA;
        end
        // Second return stage is split per owner so the strobes come straight from flops.
        core_rvalid_d = rd_issued_q && (rd_owner_q == OWN_CORE);
        dma_rvalid_d  = rd_issued_q && (rd_owner_q == OWN_DMA);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            ram_we_q      <= 1'b0;
            rd_issued_q   <= 1'b0;
            rd_owner_q    <= OWN_CORE;
            core_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
        end else begin
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            ram_we_q      <= ram_we_d;
            rd_issued_q   <= rd_issued_d;
            rd_owner_q    <= rd_owner_d;
            core_rvalid_q <= core_rvalid_d;
            dma_rvalid_q  <= dma_rvalid_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ram_we      = ram_we_q;
    assign core_rvalid = core_rvalid_q;
    assign dma_rvalid  = dma_rvalid_q;
    assign rdata       = ram_rdata;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: a RAM model, a transaction-level scoreboard
// compared every cycle, and directed scenarios with hand-computed literal expectations.
module tb_vram_port_arbiter;
    localparam int LIMIT = 4;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, dma_req, dma_we;
    logic [23:0] core_addr, dma_addr;
    logic [15:0] core_wdata, dma_wdata;
    logic        core_gnt, core_rvalid, dma_gnt, dma_rvalid;
    logic [15:0] rdata, ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic [23:0] ram_addr;
    logic        ram_we;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    vram_port_arbiter #(.ADDR_W(24), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .rdata(rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous-read RAM: returns the pre-write contents of the sampled address.
    logic [15:0] ram_mem [logic [23:0]];
    always @(posedge clk) begin
        ram_rdata <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 16'h0;
        if (ram_we) ram_mem[ram_addr] = ram_wdata;
        cyc++;
    end

    // Scoreboard: transfers are applied to a shadow memory in issue order; each read
    // becomes an expected return due two edges after its transfer edge.
    typedef struct { int due; bit dma; logic [15:0] data; } ret_t;
    ret_t        rq[$];
    logic [15:0] shadow [logic [23:0]];
    logic [23:0] exp_addr = '0;
    logic [15:0] exp_wdata = '0;
    logic        exp_we = 1'b0;
    int          waited = 0;

    always @(negedge clk) begin
        bit          ev_c, ev_d, eg_c, eg_d, w;
        logic [15:0] ed, wd;
        logic [23:0] a;
        ret_t        r;
        if (reset) begin
            chk("rst_core_gnt", core_gnt, 0);
            chk("rst_dma_gnt", dma_gnt, 0);
            chk("rst_core_rvalid", core_rvalid, 0);
            chk("rst_dma_rvalid", dma_rvalid, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_wdata", ram_wdata, 0);
            rq.delete();
            exp_addr = '0; exp_wdata = '0; exp_we = 1'b0; waited = 0;
        end else begin
            ev_c = 1'b0; ev_d = 1'b0; ed = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                r = rq.pop_front();
                ev_c = !r.dma; ev_d = r.dma; ed = r.data;
            end
            chk("core_rvalid", core_rvalid, ev_c);
            chk("dma_rvalid", dma_rvalid, ev_d);
            if (ev_c || ev_d) chk("rdata", rdata, ed);
            chk("ram_addr", ram_addr, exp_addr);
            chk("ram_we", ram_we, exp_we);
            chk("ram_wdata", ram_wdata, exp_wdata);

            eg_c = core_req && !(GUARD && dma_req && waited >= LIMIT);
            eg_d = dma_req && !eg_c;
            chk("core_gnt", core_gnt, eg_c);
            chk("dma_gnt", dma_gnt, eg_d);

            exp_we = 1'b0;
            if (eg_c || eg_d) begin
                w  = eg_c ? core_we : dma_we;
                a  = eg_c ? core_addr : dma_addr;
                wd = eg_c ? core_wdata : dma_wdata;
                exp_addr = a; exp_wdata = wd; exp_we = w;
                if (w) shadow[a] = wd;
                else rq.push_back('{cyc + 2, eg_d, shadow.exists(a) ? shadow[a] : 16'h0});
            end
            if (!dma_req || eg_d) waited = 0;
            else if (eg_c && waited < 15) waited++;
        end
    end

    task automatic idle();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        dma_req  = 1'b0; dma_we  = 1'b0; dma_addr  = '0; dma_wdata  = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        int n_c, n_d, nrv;
        logic [31:0] mask;
        logic [23:0] ca, da;

        ram_mem[24'h10] = 16'hBEEF; shadow[24'h10] = 16'hBEEF;
        for (int i = 0; i < 8; i++) begin
            ram_mem[24'h100 + 24'(i)] = 16'hA000 + 16'(i);
            shadow[24'h100 + 24'(i)]  = 16'hA000 + 16'(i);
        end

        // Reset with a request pending: grants must stay low.
        idle(); reset = 1'b1; core_req = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("init_gnt_low", core_gnt, 0);
        chk("init_ram_we", ram_we, 0);
        step(); reset = 1'b0; idle();
        step();

        // Core read of 0x10 returns 0xBEEF two edges after grant.
        core_req = 1'b1; core_we = 1'b0; core_addr = 24'h10;
        @(negedge clk); chk("cr_gnt", core_gnt, 1); chk("cr_dma_gnt", dma_gnt, 0);
        step(); idle();
        @(negedge clk); chk("cr_rv_early", core_rvalid, 0);
        step();
        @(negedge clk);
        chk("cr_rvalid", core_rvalid, 1); chk("cr_rdata", rdata, 16'hBEEF);
        chk("cr_dma_rvalid", dma_rvalid, 0);
        step(); step();

        // DMA write then read of the same address on consecutive cycles.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 24'h20; dma_wdata = 16'h1234;
        step();
        dma_we = 1'b0; dma_wdata = 16'h0;
        @(negedge clk); chk("wr_ram_we", ram_we, 1); chk("wr_ram_wdata", ram_wdata, 16'h1234);
        step(); idle();
        @(negedge clk); chk("rd_ram_we", ram_we, 0); chk("rd_ram_addr", ram_addr, 24'h20);
        step();
        @(negedge clk); chk("war_rvalid", dma_rvalid, 1); chk("war_rdata", rdata, 16'h1234);
        step(); step();

        // Contention: both requesters read continuously for 20 cycles.
        ca = 24'h200; da = 24'h300; n_c = 0; n_d = 0; mask = '0;
        for (int i = 0; i < 20; i++) begin
            core_req = 1'b1; core_addr = ca; dma_req = 1'b1; dma_addr = da;
            @(negedge clk);
            if (core_gnt) begin n_c++; ca = ca + 24'd1; end
            if (dma_gnt)  begin n_d++; da = da + 24'd1; mask[i] = 1'b1; end
            step();
        end
`ifdef VRAM_ARB_STARVE_GUARD_EN
        chk("cont_core_cnt", n_c, 16);
        chk("cont_dma_cnt", n_d, 4);
        chk("cont_pattern", mask, 32'h0008_4210);
`else
        chk("cont_core_cnt", n_c, 20);
        chk("cont_dma_cnt", n_d, 0);
`endif
        core_req = 1'b0; dma_addr = da;
        @(negedge clk); chk("cont_dma_after_drop", dma_gnt, 1);
        step(); idle();
        step(); step(); step();

        // Streaming alternating reads at full rate.
        nrv = 0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (i < 8) begin
                if (i % 2 == 0) begin core_req = 1'b1; core_addr = 24'h100 + 24'(i); end
                else begin dma_req = 1'b1; dma_addr = 24'h100 + 24'(i); end
            end
            @(negedge clk);
            nrv += int'(core_rvalid) + int'(dma_rvalid);
            chk("stream_single_rv", core_rvalid & dma_rvalid, 0);
            step();
        end
        chk("stream_rv_count", nrv, 8);
        idle(); step();

        // Reset mid-stream with two reads in flight.
        core_req = 1'b1; core_addr = 24'h10;
        step();
        core_addr = 24'h101;
        step();
        #2 reset = 1'b1;
        #1;
        chk("arst_core_rvalid", core_rvalid, 0);
        chk("arst_dma_rvalid", dma_rvalid, 0);
        chk("arst_ram_we", ram_we, 0);
        chk("arst_ram_addr", ram_addr, 0);
        chk("arst_ram_wdata", ram_wdata, 0);
        chk("arst_core_gnt", core_gnt, 0);
        @(negedge clk);
        step(); reset = 1'b0; idle();
        nrv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nrv += int'(core_rvalid) + int'(dma_rvalid);
            step();
        end
        chk("post_rst_no_rvalid", nrv, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares the core-side read/write port (port A) of the dual-port video RAM between the CPU core and a DMA requester (blitter/loader). Each requester gets a valid/grant handshake. Transfers are issued to the RAM through a registered issue stage, and read data is returned with a per-requester valid strobe. It sits between the core/DMA and the memory controller's port A; port B (VGA scan-out) is untouched.

## Interface
- `ADDR_W`, 24: requester and RAM address width.
- `DATA_W`, 16: data width.
- `STARVE_LIMIT`, 4: consecutive core transfers allowed while DMA waits (guard build only), 1..15.
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `core_req`  in  1: core transfer request.
- `core_we`  in  1: 1 = write, 0 = read.
- `core_addr`  in  ADDR_W: core address.
- `core_wdata`  in  DATA_W: core write data.
- `core_gnt`  out  1: core transfer accepted this cycle.
- `core_rvalid`  out  1: `rdata` holds the core's read result.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_gnt`, `dma_rvalid`: same as the core set, for DMA.
- `rdata`  out  DATA_W: shared read-return bus.
- `ram_addr`  out  ADDR_W: to RAM port A address.
- `ram_we`  out  1: to RAM port A write enable.
- `ram_wdata`  out  DATA_W: to RAM port A data in.
- `ram_rdata`  in  DATA_W: from RAM port A data out (1-cycle synchronous read).

## Operation
- **Handshake.** A transfer occurs on a rising edge where `X_req && X_gnt`.
  - The requester holds `we`, `addr` and `wdata` stable while `req` is high and not granted.
  - The requester may present a new transfer in the very next cycle.
- **Grants.**
  - `core_gnt` and `dma_gnt` are combinational from the `req` inputs and the registered priority state.
  - At most one grant is high per cycle.
  - `gnt` is never high without its `req`.
- **Default priority.** Core wins over DMA.
- **Issue stage.** On a transfer edge, the winner's `addr`, `wdata` and `we` are registered into `ram_addr`, `ram_wdata` and `ram_we`.
  - With no transfer: `ram_we` = 0; `ram_addr` and `ram_wdata` hold their last values.
- **Read return.** A 2-deep shift register carries {read_issued, owner}.
  - `X_rvalid` pulses for 1 cycle with `rdata` = `ram_rdata`.
  - Writes produce no `rvalid`.
- **Combinational return path.** `rdata` is a wire from `ram_rdata`; it is valid only when an `rvalid` is high.
- **Priority state.** A 4-bit counter `starve_cnt` (guard build only, see Configuration).
- **Reset behaviour.** Asynchronous reset clears all state immediately.
  - `ram_we`, `ram_addr`, `ram_wdata` = 0.
  - Both `rvalid` = 0 and `starve_cnt` = 0.
  - In-flight reads are dropped: no `rvalid` is ever produced for a transfer issued before reset.
  - Grants are low while reset is high.

## Timing
- **Transfer edge.** Transfer at edge E0 → `ram_addr`/`ram_we` valid after E0 → RAM samples at E1 → `X_rvalid` = 1 during the cycle after E1. Read latency is 2 cycles from the grant edge.
- **Write latency.** A write is committed in the RAM at E1.
- **Throughput.** 1 transfer per cycle, sustained, in any mix of requesters, reads and writes.
- **Ordering.** Return order equals issue order. No two `rvalid` signals are ever high in the same cycle.
- **Simultaneous requests.** Resolved per Configuration. The loser's request stays pending with no timeout.
- **Back-to-back pairs.**
  - Write then read to the same address (any requester) in consecutive cycles: the read returns the new data, because the RAM port is read-after-write ordered by issue.
  - Read-during-write on the same edge cannot occur at port A.

## Configuration
- Macro: `VRAM_ARB_STARVE_GUARD_EN`.
- **Defined:**
  - `starve_cnt` increments on each core transfer while `dma_req` is high.
  - It clears on any DMA transfer, or on any cycle with `dma_req` low.
  - When `starve_cnt == STARVE_LIMIT` and `dma_req` is high, DMA gets the grant even if `core_req` is high.
  - The counter saturates; it never wraps.
- **Undefined:**
  - Strict core priority; DMA may starve indefinitely.
  - No counter logic is synthesised, and `STARVE_LIMIT` is unused.

## Test plan
- **Reset:** assert `reset` mid-stream with 2 reads in flight → all outputs 0 asynchronously; no `rvalid` after deassert; `ram_we` = 0.
- **Core read:** `core_req`, `core_addr` = 0x000010, `we` = 0, RAM model returns 0xBEEF → `core_gnt` same cycle; `core_rvalid` = 1 with `rdata` = 0xBEEF exactly 2 cycles after the grant edge; `dma_rvalid` stays 0.
- **Write then read:** DMA write 0x1234 to 0x000020, then DMA read 0x000020 on the next cycle → `ram_we` pulses once; `dma_rvalid` returns 0x1234 three cycles after the first grant edge.
- **Contention, guard defined (`STARVE_LIMIT` = 4):** `core_req` and `dma_req` held high continuously → grant pattern C,C,C,C,D repeating; `rvalid` owners follow the same pattern, delayed 2 cycles.
- **Contention, guard undefined:** same stimulus for 20 cycles → 20 core grants, 0 DMA grants; DMA is granted on the first cycle `core_req` drops.
- **Streaming:** alternating core/DMA reads over 8 addresses at full rate → 8 `rvalid` pulses, in issue order, each with the correct owner and data; never two `rvalid` in one cycle.
